// File: rtl/fram_burst_ctrl_if.sv
// I2C master command, data and status signals as seen by the FRAM burst controller.
interface fram_burst_ctrl_if;
    logic [6:0] cmd_address;
    logic       cmd_start;
    logic       cmd_read;
    logic       cmd_write;
    logic       cmd_write_multiple;
    logic       cmd_stop;
    logic       cmd_valid;
    logic       cmd_ready;

    logic [7:0] tx_tdata;
    logic       tx_tvalid;
    logic       tx_tlast;
    logic       tx_tready;

    logic [7:0] rx_tdata;
    logic       rx_tvalid;
    logic       rx_tlast;
    logic       rx_tready;

    logic       i2c_busy;
    logic       i2c_missed_ack;

    // Controller side.
    modport master (
        output cmd_address, cmd_start, cmd_read, cmd_write, cmd_write_multiple, cmd_stop,
        output cmd_valid, tx_tdata, tx_tvalid, tx_tlast, rx_tready,
        input  cmd_ready, tx_tready, rx_tdata, rx_tvalid, rx_tlast, i2c_busy, i2c_missed_ack
    );

    // I2C master side.
    modport slave (
        input  cmd_address, cmd_start, cmd_read, cmd_write, cmd_write_multiple, cmd_stop,
        input  cmd_valid, tx_tdata, tx_tvalid, tx_tlast, rx_tready,
        output cmd_ready, tx_tready, rx_tdata, rx_tvalid, rx_tlast, i2c_busy, i2c_missed_ack
    );
endinterface

// File: rtl/fram_burst_ctrl.sv
// FRAM burst controller: turns one request into a random-address burst read or write
// through an AXI-Stream I2C master, with missed-ACK abort and done/error status pulses.
module fram_burst_ctrl #(
    parameter int unsigned  ADDR_BYTES = 1,
    parameter int unsigned  MAX_BURST  = 16,
    parameter logic [2:0]   DEV_SEL    = 3'b000,
    localparam int unsigned LEN_W      = $clog2(MAX_BURST + 1)
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    req_valid_i,
    output logic                    req_ready_o,
    input  logic                    req_write_i,
    input  logic [8*ADDR_BYTES-1:0] req_addr_i,
    input  logic [LEN_W-1:0]        req_len_i,
    input  logic [7:0]              wr_tdata_i,
    input  logic                    wr_tvalid_i,
    output logic                    wr_tready_o,
    output logic [7:0]              rd_tdata_o,
    output logic                    rd_tvalid_o,
    output logic                    rd_tlast_o,
    input  logic                    rd_tready_i,
    output logic                    done_o,
    output logic                    error_o,
    output logic                    busy_o,
    fram_burst_ctrl_if.master       i2c
);
    localparam logic [6:0]       SlaveAddr    = {4'b1010, DEV_SEL};
    localparam logic [LEN_W-1:0] MaxLen       = LEN_W'(MAX_BURST);
    localparam logic [LEN_W-1:0] LastAddrBeat = LEN_W'(ADDR_BYTES - 1);
    localparam logic [LEN_W-1:0] One          = LEN_W'(1);

    typedef enum logic [3:0] {
        StIdle, StReject, StCmdWr, StAddr, StDataWr, StStop, StRd, StWaitIdle, StAbort
    } state_e;

    state_e                  state_q, state_d;
    logic [8*ADDR_BYTES-1:0] addr_q, addr_d;
    logic [LEN_W-1:0]        len_q, len_d;
    logic [LEN_W-1:0]        cnt_q, cnt_d;    // address/data beats, or read commands in RD
    logic [LEN_W-1:0]        rcnt_q, rcnt_d;  // read bytes delivered
    logic                    write_q, write_d;
    logic                    abort_q, abort_d;
    logic                    done_q, done_d;
    logic                    error_q, error_d;
    logic                    busy_q;
    logic [LEN_W-1:0]        len_last;
    logic                    abortable;
    logic                    rd_cmd_pend;

    // The master's own tlast is redundant: the final read byte is known from the count.
    logic unused_rx_tlast;
    assign unused_rx_tlast = i2c.rx_tlast;

    assign len_last    = len_q - One;
    assign rd_cmd_pend = (cnt_q != len_q);
    assign abortable   = (state_q == StCmdWr) || (state_q == StAddr) || (state_q == StDataWr) ||
                         (state_q == StStop)  || (state_q == StRd);
    assign done_o      = done_q;
    assign error_o     = error_q;
    assign busy_o      = busy_q;

    // Next-state, counters and all bus/stream outputs decoded from the registered state.
    always_comb begin
        state_d                = state_q;
        addr_d                 = addr_q;
        len_d                  = len_q;
        cnt_d                  = cnt_q;
        rcnt_d                 = rcnt_q;
        write_d                = write_q;
        abort_d                = abort_q;
        done_d                 = 1'b0;
        error_d                = 1'b0;
        req_ready_o            = (state_q == StIdle) && !i2c.i2c_busy;
        wr_tready_o            = 1'b0;
        rd_tdata_o             = 8'h00;
        rd_tvalid_o            = 1'b0;
        rd_tlast_o             = 1'b0;
        i2c.cmd_address        = 7'h00;
        i2c.cmd_start          = 1'b0;
        i2c.cmd_read           = 1'b0;
        i2c.cmd_write          = 1'b0;
        i2c.cmd_write_multiple = 1'b0;
        i2c.cmd_stop           = 1'b0;
        i2c.cmd_valid          = 1'b0;
        i2c.tx_tdata           = 8'h00;
        i2c.tx_tvalid          = 1'b0;
        i2c.tx_tlast           = 1'b0;
        i2c.rx_tready          = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (req_valid_i && req_ready_o) begin
                    addr_d  = req_addr_i;
                    len_d   = req_len_i;
                    write_d = req_write_i;
                    cnt_d   = '0;
                    rcnt_d  = '0;
                    abort_d = 1'b0;
                    state_d = (req_len_i == '0 || req_len_i > MaxLen) ? StReject : StCmdWr;
                end
            end
            StReject: begin
                error_d = 1'b1;
                state_d = StIdle;
            end
            StCmdWr: begin
                i2c.cmd_valid          = 1'b1;
                i2c.cmd_write_multiple = 1'b1;
                i2c.cmd_address        = SlaveAddr;
                if (i2c.cmd_ready) state_d = StAddr;
            end
            StAddr: begin
                // addr_q shifts left per beat so the top byte is always the next one out.
                i2c.tx_tvalid = 1'b1;
                i2c.tx_tdata  = addr_q[8*ADDR_BYTES-1 -: 8];
                i2c.tx_tlast  = !write_q && (cnt_q == LastAddrBeat);
                if (i2c.tx_tready) begin
                    addr_d = addr_q << 8;
                    if (cnt_q == LastAddrBeat) begin
                        cnt_d   = '0;
                        state_d = write_q ? StDataWr : StRd;
                    end else begin
                        cnt_d = cnt_q + One;
                    end
                end
            end
            StDataWr: begin
                i2c.tx_tdata  = wr_tdata_i;
                i2c.tx_tvalid = wr_tvalid_i;
                i2c.tx_tlast  = (cnt_q == len_last);
                wr_tready_o   = i2c.tx_tready;
                if (wr_tvalid_i && i2c.tx_tready) begin
                    cnt_d = cnt_q + One;
                    if (cnt_q == len_last) state_d = StStop;
                end
            end
            StStop: begin
                i2c.cmd_valid = 1'b1;
                i2c.cmd_stop  = 1'b1;
                if (i2c.cmd_ready) state_d = StWaitIdle;
            end
            StRd: begin
                // Read commands carry the device address so the master emits Sr + 0xA1.
                i2c.cmd_address = SlaveAddr;
                i2c.cmd_valid   = rd_cmd_pend;
                i2c.cmd_read    = rd_cmd_pend;
                i2c.cmd_stop    = rd_cmd_pend && (cnt_q == len_last);
                if (rd_cmd_pend && i2c.cmd_ready) cnt_d = cnt_q + One;
                if (rcnt_q != len_q) begin
                    rd_tdata_o    = i2c.rx_tdata;
                    rd_tvalid_o   = i2c.rx_tvalid;
                    rd_tlast_o    = (rcnt_q == len_last);
                    i2c.rx_tready = rd_tready_i;
                    if (i2c.rx_tvalid && rd_tready_i) rcnt_d = rcnt_q + One;
                end
                if (cnt_d == len_q && rcnt_d == len_q) state_d = StWaitIdle;
            end
            StWaitIdle: begin
                i2c.rx_tready = 1'b1;
                if (!i2c.i2c_busy) begin
                    state_d = StIdle;
                    done_d  = !abort_q;
                    error_d = abort_q;
                end
            end
            StAbort: begin
                i2c.rx_tready = 1'b1;
                i2c.cmd_valid = 1'b1;
                i2c.cmd_stop  = 1'b1;
                if (i2c.cmd_ready) state_d = StWaitIdle;
            end
            default: state_d = StIdle;
        endcase

        // A missed ACK wins over any handshake completing in the same cycle.
        if (abortable && i2c.i2c_missed_ack) begin
            state_d = StAbort;
            abort_d = 1'b1;
        end
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= StIdle;
            addr_q  <= '0;
            len_q   <= '0;
            cnt_q   <= '0;
            rcnt_q  <= '0;
            write_q <= 1'b0;
            abort_q <= 1'b0;
            done_q  <= 1'b0;
            error_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
            rcnt_q  <= rcnt_d;
            write_q <= write_d;
            abort_q <= abort_d;
            done_q  <= done_d;
            error_q <= error_d;
            busy_q  <= (state_d != StIdle);
        end
    end
endmodule

// File: tb/tb_fram_burst_ctrl.sv
// Bench for fram_burst_ctrl: transaction-level I2C master + FRAM model, expected bus
// sequences and read data built from a reference memory.
module tb_fram_burst_ctrl;
    localparam int AddrBytes = 2;
    localparam int MaxBurst  = 16;
    localparam int LenW      = $clog2(MaxBurst + 1);
    localparam int TokStart  = 256;
    localparam int TokSr     = 257;
    localparam int TokStop   = 258;
    localparam int TokLast   = 259;

    logic            clk_i = 1'b0;
    logic            rst_i = 1'b1;
    logic            req_valid_i = 1'b0;
    logic            req_ready_o;
    logic            req_write_i = 1'b0;
    logic [15:0]     req_addr_i = '0;
    logic [LenW-1:0] req_len_i = '0;
    logic [7:0]      wr_tdata_i = '0;
    logic            wr_tvalid_i = 1'b0;
    logic            wr_tready_o;
    logic [7:0]      rd_tdata_o;
    logic            rd_tvalid_o;
    logic            rd_tlast_o;
    logic            rd_tready_i = 1'b0;
    logic            done_o, error_o, busy_o;

    fram_burst_ctrl_if bus ();

    fram_burst_ctrl #(
        .ADDR_BYTES (AddrBytes),
        .MAX_BURST  (MaxBurst),
        .DEV_SEL    (3'b000)
    ) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .req_valid_i (req_valid_i),
        .req_ready_o (req_ready_o),
        .req_write_i (req_write_i),
        .req_addr_i  (req_addr_i),
        .req_len_i   (req_len_i),
        .wr_tdata_i  (wr_tdata_i),
        .wr_tvalid_i (wr_tvalid_i),
        .wr_tready_o (wr_tready_o),
        .rd_tdata_o  (rd_tdata_o),
        .rd_tvalid_o (rd_tvalid_o),
        .rd_tlast_o  (rd_tlast_o),
        .rd_tready_i (rd_tready_i),
        .done_o      (done_o),
        .error_o     (error_o),
        .busy_o      (busy_o),
        .i2c         (bus)
    );

    always #5 clk_i = ~clk_i;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // I2C master / FRAM model state
    int         log_q[$];
    logic [7:0] dev_mem [65536];
    logic [7:0] ref_mem [65536];
    logic [7:0] rxq[$];
    bit         m_active, m_rd_mode, m_nacked, nack_dev, rx_pop;
    int         m_txcnt, ack_cd, busy_cd;
    logic [15:0] m_ptr;

    // Requester side and monitors
    logic [7:0] wr_q[$];
    logic [7:0] fix_data[$];
    logic [8:0] rd_got[$];
    bit         pend_req, wr_pop, slow_rd;
    int         slow_cnt, cyc, acc_cyc, cmd1_cyc, err_cyc, n_done, n_err, n_both, n_cmdv;

    // Drive everything just after the falling edge, then sample 1 time unit later; what is
    // seen then is exactly what the DUT will act on at the next rising edge.
    always begin
        @(negedge clk_i);
        bus.cmd_ready = ($urandom_range(0, 3) != 0);
        bus.tx_tready = !m_nacked && ($urandom_range(0, 3) != 0);
        if (rx_pop) begin
            bus.rx_tvalid = 1'b0;
            rx_pop = 1'b0;
        end
        if (!bus.rx_tvalid && rxq.size() > 0 && $urandom_range(0, 1) == 1) begin
            bus.rx_tvalid = 1'b1;
            bus.rx_tdata  = rxq[0];
        end
        bus.rx_tlast       = 1'($urandom_range(0, 1));
        bus.i2c_missed_ack = (ack_cd == 1);
        bus.i2c_busy       = m_active || (busy_cd > 0);
        if (wr_pop) begin
            wr_tvalid_i = 1'b0;
            wr_pop = 1'b0;
        end
        if (!wr_tvalid_i && wr_q.size() > 0 && $urandom_range(0, 2) != 0) begin
            wr_tvalid_i = 1'b1;
            wr_tdata_i  = wr_q[0];
        end
        rd_tready_i = slow_rd ? (slow_cnt >= 10) : ($urandom_range(0, 3) != 0);
        req_valid_i = pend_req;
        #1;
        if (rst_i) begin
            m_active = 0; m_rd_mode = 0; m_nacked = 0; nack_dev = 0; pend_req = 0;
            ack_cd = 0; busy_cd = 0; rxq.delete(); rx_pop = 1; wr_pop = 1;
        end else begin
            if (req_valid_i && req_ready_o) begin
                pend_req = 0;
                acc_cyc = cyc;
            end
            if (bus.cmd_valid && cmd1_cyc < 0 && acc_cyc >= 0) cmd1_cyc = cyc;
            if (bus.cmd_valid) n_cmdv++;
            if (done_o) n_done++;
            if (error_o) begin
                n_err++;
                if (err_cyc < 0) err_cyc = cyc;
            end
            if (done_o && error_o) n_both++;
            if (rd_tvalid_o && rd_tready_i) begin
                rd_got.push_back({rd_tlast_o, rd_tdata_o});
                slow_cnt = 0;
            end else begin
                slow_cnt++;
            end
            if (wr_tvalid_i && wr_tready_o) begin
                void'(wr_q.pop_front());
                wr_pop = 1;
            end
            if (bus.rx_tvalid && bus.rx_tready) begin
                void'(rxq.pop_front());
                rx_pop = 1;
            end
            if (bus.cmd_valid && bus.cmd_ready) begin
                if (bus.cmd_write_multiple) begin
                    log_q.push_back(m_active ? TokSr : TokStart);
                    log_q.push_back(int'({bus.cmd_address, 1'b0}));
                    m_active = 1; m_rd_mode = 0; m_txcnt = 0;
                    if (nack_dev) begin
                        m_nacked = 1; ack_cd = 3; nack_dev = 0;
                    end
                end else if (bus.cmd_read) begin
                    if (!m_active || !m_rd_mode) begin
                        log_q.push_back(m_active ? TokSr : TokStart);
                        log_q.push_back(int'({bus.cmd_address, 1'b1}));
                    end
                    m_active = 1; m_rd_mode = 1;
                    log_q.push_back(int'(dev_mem[m_ptr]));
                    rxq.push_back(dev_mem[m_ptr]);
                    m_ptr++;
                end
                if (bus.cmd_stop) begin
                    log_q.push_back(TokStop);
                    m_active = 0; m_rd_mode = 0; m_nacked = 0; busy_cd = 4;
                end
            end
            if (bus.tx_tvalid && bus.tx_tready) begin
                log_q.push_back(int'(bus.tx_tdata));
                if (bus.tx_tlast) log_q.push_back(TokLast);
                if (m_txcnt < AddrBytes) begin
                    m_ptr = {m_ptr[7:0], bus.tx_tdata};
                end else begin
                    dev_mem[m_ptr] = bus.tx_tdata;
                    m_ptr++;
                end
                m_txcnt++;
            end
            if (ack_cd > 0) ack_cd--;
            if (busy_cd > 0) busy_cd--;
        end
        cyc++;
    end

    task automatic tick();
        @(posedge clk_i);
        #2;
    endtask

    task automatic start_req(input bit wr, input logic [15:0] addr, input int len, input bit nack);
        tick();
        log_q.delete(); rd_got.delete();
        n_done = 0; n_err = 0; n_both = 0; n_cmdv = 0;
        acc_cyc = -1; cmd1_cyc = -1; err_cyc = -1;
        wr_q.delete(); wr_pop = 1;
        req_write_i = wr; req_addr_i = addr; req_len_i = LenW'(len);
        nack_dev = nack; pend_req = 1;
    endtask

    // Issue one request, wait for its status pulse, compare bus log, read data and status.
    task automatic run_req(input bit wr, input logic [15:0] addr, input int len, input bit nack,
                           input string tag);
        int         exp_log[$];
        logic [8:0] exp_rd[$];
        logic [15:0] p;
        logic [7:0] b;
        bit         bad;
        int         guard;
        int         n;
        bad = (len == 0) || (len > MaxBurst);
        start_req(wr, addr, len, nack);
        p = addr;
        if (wr) begin
            for (int i = 0; i < len && i < MaxBurst; i++) begin
                b = (fix_data.size() == len) ? fix_data[i] : 8'($urandom);
                wr_q.push_back(b);
            end
        end
        if (!bad) begin
            exp_log.push_back(TokStart);
            exp_log.push_back(8'hA0);
            if (nack) begin
                exp_log.push_back(TokStop);
            end else begin
                exp_log.push_back(int'(addr[15:8]));
                exp_log.push_back(int'(addr[7:0]));
                if (wr) begin
                    for (int i = 0; i < len; i++) begin
                        exp_log.push_back(int'(wr_q[i]));
                        if (i == len - 1) exp_log.push_back(TokLast);
                        ref_mem[p] = wr_q[i];
                        p++;
                    end
                end else begin
                    exp_log.push_back(TokLast);
                    exp_log.push_back(TokSr);
                    exp_log.push_back(8'hA1);
                    for (int i = 0; i < len; i++) begin
                        exp_log.push_back(int'(ref_mem[p]));
                        exp_rd.push_back({i == len - 1, ref_mem[p]});
                        p++;
                    end
                end
                exp_log.push_back(TokStop);
            end
        end
        guard = 0;
        while (n_done + n_err == 0 && guard < 3000) begin
            tick();
            guard++;
        end
        check_eq({tag, " status_timeout"}, guard < 3000, 1);
        repeat (6) tick();
        check_eq({tag, " done_count"}, n_done, (!bad && !nack) ? 1 : 0);
        check_eq({tag, " error_count"}, n_err, (bad || nack) ? 1 : 0);
        check_eq({tag, " done_and_error"}, n_both, 0);
        check_eq({tag, " bus_log_len"}, log_q.size(), exp_log.size());
        n = (log_q.size() < exp_log.size()) ? log_q.size() : exp_log.size();
        for (int i = 0; i < n; i++) check_eq({tag, " bus_log"}, log_q[i], exp_log[i]);
        check_eq({tag, " rd_len"}, rd_got.size(), exp_rd.size());
        n = (rd_got.size() < exp_rd.size()) ? rd_got.size() : exp_rd.size();
        for (int i = 0; i < n; i++) check_eq({tag, " rd_data_last"}, rd_got[i], exp_rd[i]);
        if (bad) begin
            check_eq({tag, " reject_no_cmd"}, n_cmdv, 0);
            check_eq({tag, " reject_err_latency"}, (err_cyc - acc_cyc) <= 2 && acc_cyc >= 0, 1);
        end else begin
            check_eq({tag, " cmd_after_accept"}, cmd1_cyc - acc_cyc, 1);
        end
        if (wr && nack) check_eq({tag, " wr_bytes_kept"}, wr_q.size(), len);
        check_eq({tag, " req_ready_after"}, req_ready_o, 1);
    endtask

    initial begin
        int guard;
        bus.cmd_ready = 0; bus.tx_tready = 0; bus.rx_tdata = 0; bus.rx_tvalid = 0;
        bus.rx_tlast = 0; bus.i2c_busy = 0; bus.i2c_missed_ack = 0;
        cyc = 0; acc_cyc = -1; cmd1_cyc = -1; err_cyc = -1; slow_cnt = 0;
        for (int i = 0; i < 65536; i++) begin
            dev_mem[i] = 8'($urandom);
            ref_mem[i] = dev_mem[i];
        end
        repeat (3) @(posedge clk_i);
        #1;
        check_eq("reset_outputs", {busy_o, done_o, error_o, bus.cmd_valid, bus.tx_tvalid,
                                   wr_tready_o, rd_tvalid_o, bus.rx_tready}, 8'h00);
        check_eq("reset_req_ready", req_ready_o, 1);
        @(negedge clk_i);
        rst_i = 0;

        fix_data = '{8'hA5, 8'h5A, 8'hFF};
        run_req(1, 16'h0004, 3, 0, "wr3");
        fix_data.delete();

        dev_mem[16'h1234] = 8'h11; dev_mem[16'h1235] = 8'h22;
        dev_mem[16'h1236] = 8'h33; dev_mem[16'h1237] = 8'h44;
        ref_mem[16'h1234] = 8'h11; ref_mem[16'h1235] = 8'h22;
        ref_mem[16'h1236] = 8'h33; ref_mem[16'h1237] = 8'h44;
        run_req(0, 16'h1234, 4, 0, "rd4");
        run_req(0, 16'h0004, 3, 0, "rd_back_wr3");

        slow_rd = 1;
        run_req(0, 16'h0200, 2, 0, "slow_rd2");
        slow_rd = 0;

        run_req(1, 16'h0300, 4, 1, "nack_wr");
        run_req(0, 16'h0300, 2, 1, "nack_rd");
        run_req(1, 16'h0010, 0, 0, "len0");
        run_req(0, 16'h0010, MaxBurst + 1, 0, "len_over");
        run_req(1, 16'h0400, MaxBurst, 0, "wr_max");
        run_req(0, 16'h0400, MaxBurst, 0, "rd_max");

        // Reset in the middle of a write's data phase.
        start_req(1, 16'h8000, 8, 0);
        for (int i = 0; i < 8; i++) wr_q.push_back(8'($urandom));
        guard = 0;
        while (log_q.size() < 5 && guard < 500) begin
            tick();
            guard++;
        end
        check_eq("mid_rst_reach_data", guard < 500, 1);
        @(negedge clk_i);
        rst_i = 1;
        @(posedge clk_i);
        #1;
        check_eq("mid_rst_outputs", {busy_o, done_o, error_o, bus.cmd_valid, bus.tx_tvalid,
                                     wr_tready_o, rd_tvalid_o, bus.rx_tready}, 8'h00);
        check_eq("mid_rst_req_ready", req_ready_o, !bus.i2c_busy);
        @(negedge clk_i);
        rst_i = 0;
        run_req(1, 16'h0500, 1, 0, "post_rst_wr1");
        run_req(0, 16'h0500, 1, 0, "post_rst_rd1");

        for (int t = 0; t < 24; t++) begin
            int l;
            bit w;
            logic [15:0] a;
            w = 1'($urandom_range(0, 1));
            a = 16'($urandom_range(0, 4095));
            l = $urandom_range(1, MaxBurst);
            if ($urandom_range(0, 9) == 0) l = ($urandom_range(0, 1) == 1) ? 0 : MaxBurst + 1;
            slow_rd = ($urandom_range(0, 7) == 0);
            run_req(w, a, l, 1'($urandom_range(0, 9) == 0), "rand");
        end
        slow_rd = 0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/fram_burst_ctrl.md
# fram_burst_ctrl

Parametrised FRAM access controller for FM24CLxx-family parts. It sits between a requester (debug front end, UART bridge) and the `i2c_master` AXI-Stream command/data interfaces. It turns one request into a complete random-address burst read or burst write of 1..`MAX_BURST` bytes, with 1- or 2-byte word addressing, missed-ACK abort and a done/error status.

## Interface
- `ADDR_BYTES`, 1: word-address bytes sent after the device select; legal values are 1 and 2.
- `MAX_BURST`, 16: maximum bytes per request; must be ≥1.
- `DEV_SEL`, 3'b000: low 3 bits of the 7-bit slave address. The full address is {4'b1010, `DEV_SEL`}.
- `LEN_W`, derived: $clog2(`MAX_BURST`+1).
- `clk`  in  1  system clock.
- `rst`  in  1  synchronous, active-high reset.
- `req_valid`/`req_ready`  in/out  1  request handshake.
- `req_write`  in  1  1 = write, 0 = read.
- `req_addr`  in  8*`ADDR_BYTES`  FRAM word address; most significant byte is sent first.
- `req_len`  in  `LEN_W`  byte count.
- `wr_tdata`/`wr_tvalid`/`wr_tready`  in/in/out  8/1/1  write payload stream.
- `rd_tdata`/`rd_tvalid`/`rd_tlast`/`rd_tready`  out/out/out/in  8/1/1/1  read payload stream.
- `done`, `error`  out  1  one-cycle completion pulses.
- `busy`  out  1  high whenever the FSM is not in IDLE.
- `cmd_address`, `cmd_start`, `cmd_read`, `cmd_write`, `cmd_write_multiple`, `cmd_stop`, `cmd_valid`  out  7,1,1,1,1,1,1  to the `i2c_master` `s_axis_cmd_*` inputs.
- `cmd_ready`  in  1  from the master.
- `tx_tdata`/`tx_tvalid`/`tx_tlast`  out  8/1/1  to the master `s_axis_data_*`; `tx_tready` in  1.
- `rx_tdata`/`rx_tvalid`/`rx_tlast`  in  8/1/1  from the master `m_axis_data_*`; `rx_tready` out  1.
- `i2c_busy`, `i2c_missed_ack`  in  1  master status.

## Operation
- `req_ready` = (state==IDLE) & ~`i2c_busy`. A request is accepted on `req_valid` & `req_ready`. Addr, len and dir are latched at that edge.
- `req_len`==0 or `req_len`>`MAX_BURST`: the request goes to state REJECT for one cycle, `error` pulses, and there is no bus activity.
- States: IDLE → CMD_WR → ADDR (`ADDR_BYTES` beats, byte counter) → then by direction:
  - Write: DATA_WR → STOP → WAIT_IDLE → IDLE.
  - Read: RD → WAIT_IDLE → IDLE.
- CMD_WR: `cmd_valid`=1, `cmd_write_multiple`=1, `cmd_address`={4'b1010,`DEV_SEL`}. Advances on `cmd_ready`.
- ADDR: `tx_tvalid`=1 with the address bytes, MSB first. `tx_tlast`=1 on the final address byte only for reads. Each beat advances on `tx_tready`.
- DATA_WR: `tx_tdata`=`wr_tdata`, `tx_tvalid`=`wr_tvalid`, `wr_tready`=`tx_tready`. A byte counter counts transfers. `tx_tlast`=1 on beat `len`-1. After the last beat the FSM goes to STOP.
- STOP: `cmd_valid`=1, `cmd_stop`=1. Advances on `cmd_ready`.
- RD: two independent counters run in parallel.
  - Command counter: issues `len` `cmd_read` commands with `cmd_valid`=1. The last command also has `cmd_stop`=1. The master inserts the repeated start.
  - Receive counter: `rd_tdata`=`rx_tdata`, `rd_tvalid`=`rx_tvalid`, `rx_tready`=`rd_tready`. `rd_tlast`=1 on received byte `len`-1, generated internally; `rx_tlast` is ignored.
  - RD exits when both counters reach `len`.
- WAIT_IDLE: waits for `i2c_busy`==0. `done` pulses on the transition to IDLE.
- Abort: `i2c_missed_ack` high in any state other than IDLE/REJECT/WAIT_IDLE/ABORT sends the FSM to ABORT.
  - ABORT drives `cmd_stop` with `cmd_valid` until `cmd_ready`, then goes to WAIT_IDLE.
  - `error` pulses instead of `done`. Neither pulse is ever asserted together with the other.
  - Unconsumed write bytes remain with the requester, since `wr_tready`=0 outside DATA_WR. Further rx bytes are dropped, since `rx_tready`=1 in ABORT/WAIT_IDLE.
- All command, data and ready outputs not listed for a state are 0.

## Timing
- Reset: FSM=IDLE, counters=0. `busy`, `done`, `error`, `cmd_valid`, `tx_tvalid`, `wr_tready`, `rd_tvalid` and `rx_tready` are all 0. `req_ready` is 1 if `i2c_busy`=0.
- `cmd_valid` is asserted in the first cycle after acceptance.
- The stream paths are combinational pass-throughs with 0-cycle latency. Command and data outputs are decoded from registered state only.
- `busy`, `done` and `error` are registered.
- Reset asserted mid-burst: next cycle is IDLE with all outputs at reset values. The I2C master is reset by the same `rst`.
- A missed ACK arriving on the same cycle as a state-advance handshake takes priority: the FSM goes to ABORT.
- Counters are `LEN_W` bits wide and never wrap, because the length is bounded by `MAX_BURST`.

## Test plan
- ADDR_BYTES=1, write len=3 at 0x04, data A5,5A,FF → wire sequence: START, 0xA0, 0x04, A5, 5A, FF, STOP. One `done` pulse; `tx_tlast` only on FF.
- ADDR_BYTES=2, read len=4 at 0x1234 from a model preloaded with 11,22,33,44 → wire sequence: 0xA0, 0x12, 0x34, Sr, 0xA1, 4 bytes with the last one NACKed, STOP. `rd_tdata` = 11,22,33,44; `rd_tlast` only on 44; `done`.
- Read len=2 with `rd_tready` held low 10 cycles per byte → no data lost; bytes are delivered in order.
- Slave NACKs the device address → ABORT, STOP on the bus, `error`=1 for one cycle, `done` never asserted. `req_ready` returns to 1.
- `req_len`=0 and `req_len`=`MAX_BURST`+1 → `error` pulse within 2 cycles, `cmd_valid` never asserted.
- Assert `rst` during the DATA_WR of a len=8 write → outputs return to reset values the next cycle, and a following len=1 write completes with `done`.
